// File: rtl/crossbar_pkg.sv
// Shared crossbar definitions: command encodings, slave FSM states and the
// region-decode helper used by the slaves and the crossbar decoder.
package crossbar_pkg;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } slave_state_t;

    // True when the top sel_bits of an addr_w-bit address equal sel_value.
    // The address is zero-extended into 64 bits; sel_bits = 0 always hits.
    function automatic logic addr_hit(
        input logic [63:0] addr,
        input int unsigned sel_bits,
        input logic [63:0] sel_value,
        input int unsigned addr_w = 32
    );
        logic [63:0] mask;
        mask = ~(64'hFFFF_FFFF_FFFF_FFFF << sel_bits);
        return ((addr >> (addr_w - sel_bits)) & mask) == (sel_value & mask);
    endfunction

endpackage

// File: rtl/slave_mem_array.sv
// Word-addressed register array: synchronous write, asynchronous read,
// synchronous clear. Indices at or beyond DEPTH read as zero and never write.
module slave_mem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              w_in_range;
    logic              r_in_range;

    // Range qualification of both ports (DEPTH need not be a power of two).
    always_comb begin
        w_in_range = {{(32-IDX_W){1'b0}}, waddr} < 32'(DEPTH);
        r_in_range = {{(32-IDX_W){1'b0}}, raddr} < 32'(DEPTH);
    end

    // Clear all words on reset, otherwise commit a qualified write.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem <= '{default: '0};
        end else if (we && w_in_range) begin
            mem[waddr] <= wdata;
        end
    end

    // Combinational read port.
    always_comb begin
        rdata = '0;
        if (r_in_range) begin
            rdata = mem[raddr];
        end
    end

endmodule

// File: rtl/slave_mem.sv
// Memory-backed crossbar slave: region decode, request capture, programmable
// wait states and a one-cycle ack with an out-of-range error flag.
module slave_mem
    import crossbar_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int SEL_BITS  = 1,
    parameter int SEL_VALUE = 0,
    parameter int DEPTH     = 16,
    parameter int WAIT      = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic              i_cmd,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              ack,
    output logic              o_err,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] ALL1 = '1;
    // Address bits between the word index and the select field.
    localparam logic [ADDR_W-1:0] HI_MASK = (ALL1 >> SEL_BITS) & (ALL1 << (IDX_W + 2));

    slave_state_t      state;
    slave_state_t      state_nxt;
    logic [3:0]        wait_cnt;
    logic              cmd_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;
    logic [IDX_W-1:0]  idx;
    logic              hit;
    logic              range_err;
    logic              arr_we;
    logic [DATA_W-1:0] arr_rdata;

    // Decode and range evaluation of the incoming request.
    always_comb begin
        idx       = i_addr[IDX_W+1:2];
        hit       = i_req && addr_hit(64'(i_addr), SEL_BITS, 64'(SEL_VALUE), ADDR_W);
        range_err = ({{(32-IDX_W){1'b0}}, idx} >= 32'(DEPTH)) || (|(i_addr & HI_MASK));
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and response outputs. o_rdata shows the array word during a
    // read response and the held value at all other times.
    always_comb begin
        state_nxt = state;
        ack       = 1'b0;
        o_err     = 1'b0;
        o_rdata   = rdata_q;
        arr_we    = 1'b0;
        case (state)
            S_IDLE: begin
                if (hit) begin
                    state_nxt = (WAIT > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
                ack       = 1'b1;
                o_err     = err_q;
                if (cmd_q == CMD_WRITE) begin
                    arr_we = !err_q;
                end else begin
                    o_rdata = err_q ? '0 : arr_rdata;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Capture registers, wait counter and held read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            cmd_q    <= CMD_READ;
            idx_q    <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            if (state == S_IDLE && hit) begin
                cmd_q    <= i_cmd;
                idx_q    <= idx;
                wdata_q  <= i_wdata;
                err_q    <= range_err;
                wait_cnt <= (WAIT > 0) ? 4'(WAIT - 1) : '0;
            end else if (state == S_WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (state == S_RESP && cmd_q == CMD_READ) begin
                rdata_q <= o_rdata;
            end
        end
    end

    slave_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk    (clk),
        .reset  (reset),
        .we     (arr_we),
        .waddr  (idx_q),
        .wdata  (wdata_q),
        .raddr  (idx_q),
        .rdata  (arr_rdata)
    );

endmodule

// File: tb/tb_slave_mem.sv
// Directed bench for slave_mem across several parameterisations sharing one
// clock, reset and request bus; each instance has its own request line.
module tb_slave_mem;
    import crossbar_pkg::*;

    logic        clk;
    logic        reset;
    logic        req;
    int          sel;
    logic        cmd;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic        req_v   [5];
    logic        ack_v   [5];
    logic        err_v   [5];
    logic [31:0] rdata_v [5];

    int checks;
    int errors;

    // Instance map: 0 = WAIT1/D16, 1 = WAIT1/D12, 2 = WAIT0, 3 = WAIT3, 4 = WAIT15
    slave_mem #(.DATA_W(32), .ADDR_W(32), .SEL_BITS(1), .SEL_VALUE(0), .DEPTH(16), .WAIT(1)) d1 (
        .clk(clk), .reset(reset), .i_req(req_v[0]), .i_cmd(cmd), .i_addr(addr), .i_wdata(wdata),
        .ack(ack_v[0]), .o_err(err_v[0]), .o_rdata(rdata_v[0]));
    slave_mem #(.DATA_W(32), .ADDR_W(32), .SEL_BITS(1), .SEL_VALUE(0), .DEPTH(12), .WAIT(1)) d12 (
        .clk(clk), .reset(reset), .i_req(req_v[1]), .i_cmd(cmd), .i_addr(addr), .i_wdata(wdata),
        .ack(ack_v[1]), .o_err(err_v[1]), .o_rdata(rdata_v[1]));
    slave_mem #(.DATA_W(32), .ADDR_W(32), .SEL_BITS(1), .SEL_VALUE(0), .DEPTH(16), .WAIT(0)) w0 (
        .clk(clk), .reset(reset), .i_req(req_v[2]), .i_cmd(cmd), .i_addr(addr), .i_wdata(wdata),
        .ack(ack_v[2]), .o_err(err_v[2]), .o_rdata(rdata_v[2]));
    slave_mem #(.DATA_W(32), .ADDR_W(32), .SEL_BITS(1), .SEL_VALUE(0), .DEPTH(16), .WAIT(3)) w3 (
        .clk(clk), .reset(reset), .i_req(req_v[3]), .i_cmd(cmd), .i_addr(addr), .i_wdata(wdata),
        .ack(ack_v[3]), .o_err(err_v[3]), .o_rdata(rdata_v[3]));
    slave_mem #(.DATA_W(32), .ADDR_W(32), .SEL_BITS(1), .SEL_VALUE(0), .DEPTH(16), .WAIT(15)) w15 (
        .clk(clk), .reset(reset), .i_req(req_v[4]), .i_cmd(cmd), .i_addr(addr), .i_wdata(wdata),
        .ack(ack_v[4]), .o_err(err_v[4]), .o_rdata(rdata_v[4]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Route the shared request to the selected instance only.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            req_v[i] = req && (sel == i);
        end
    end

    // One transaction on instance k; lat = edges until ack (-1 if none within
    // the bound), tail = ack one cycle later.
    task automatic do_txn(input int k, input logic c, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output logic er, output logic tail);
        @(negedge clk);
        sel = k; cmd = c; addr = a; wdata = d; req = 1'b1;
        lat = -1; rd = '0; er = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (ack_v[k]) begin
                lat = n; rd = rdata_v[k]; er = err_v[k];
                break;
            end
        end
        req = 1'b0;
        @(posedge clk); #1;
        tail = ack_v[k];
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ack_v[0] !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", ack_v[0]); end
        checks++; if (err_v[0] !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_v[0]); end
        checks++; if (rdata_v[0] !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata_v[0]); end
        checks++; if (d1.state !== S_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", d1.state, S_IDLE); end
        checks++; if (d1.wait_cnt !== 4'd0) begin errors++; $display("FAIL reset_wait_cnt got=%0d exp=0", d1.wait_cnt); end
        reset = 1'b0;
    endtask

    task automatic test_write_read();
        int lat; logic [31:0] rd; logic er; logic tail;
        do_txn(0, CMD_WRITE, 32'h0000_0008, 32'hDEAD_BEEF, lat, rd, er, tail);
        checks++; if (lat !== 2) begin errors++; $display("FAIL wr_latency got=%0d exp=2", lat); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL wr_err got=%b exp=0", er); end
        checks++; if (tail !== 1'b0) begin errors++; $display("FAIL wr_ack_width got=%b exp=0", tail); end
        checks++; if (rdata_v[0] !== 32'h0) begin errors++; $display("FAIL wr_rdata_hold got=%h exp=0", rdata_v[0]); end
        do_txn(0, CMD_READ, 32'h0000_0008, 32'h0, lat, rd, er, tail);
        checks++; if (lat !== 2) begin errors++; $display("FAIL rd_latency got=%0d exp=2", lat); end
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data got=%h exp=deadbeef", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL rd_err got=%b exp=0", er); end
        do_txn(0, CMD_WRITE, 32'h0000_000C, 32'h1111_1111, lat, rd, er, tail);
        checks++; if (rdata_v[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rdata_hold_after_wr got=%h exp=deadbeef", rdata_v[0]); end
        do_txn(0, CMD_READ, 32'h0000_000C, 32'h0, lat, rd, er, tail);
        checks++; if (rd !== 32'h1111_1111) begin errors++; $display("FAIL rd_idx3 got=%h exp=11111111", rd); end
        do_txn(0, CMD_READ, 32'h0000_000B, 32'h0, lat, rd, er, tail);
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_low_bits_ignored got=%h exp=deadbeef", rd); end
    endtask

    task automatic test_decode_miss();
        int n_ack; int n_bad; int lat; logic [31:0] rd; logic er; logic tail;
        n_ack = 0; n_bad = 0;
        @(negedge clk);
        sel = 0; cmd = CMD_READ; addr = 32'h8000_0004; req = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (ack_v[0]) n_ack++;
            if (d1.state !== S_IDLE) n_bad++;
        end
        req = 1'b0;
        checks++; if (n_ack !== 0) begin errors++; $display("FAIL miss_ack got=%0d exp=0", n_ack); end
        checks++; if (n_bad !== 0) begin errors++; $display("FAIL miss_state_not_idle got=%0d exp=0", n_bad); end
        do_txn(0, CMD_READ, 32'h0000_0040, 32'h0, lat, rd, er, tail);
        checks++; if (lat !== 2) begin errors++; $display("FAIL midbit_latency got=%0d exp=2", lat); end
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL midbit_err got=%b exp=1", er); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL midbit_rdata got=%h exp=0", rd); end
    endtask

    task automatic test_out_of_range();
        int lat; logic [31:0] rd; logic er; logic tail; logic [31:0] exp_w;
        do_txn(1, CMD_WRITE, 32'h0000_002C, 32'hA5A5_A5A5, lat, rd, er, tail);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL oor_idx11_err got=%b exp=0", er); end
        do_txn(1, CMD_WRITE, 32'h0000_0030, 32'h5555_5555, lat, rd, er, tail);
        checks++; if (lat !== 2 || er !== 1'b1) begin errors++; $display("FAIL oor_wr lat=%0d err=%b exp lat=2 err=1", lat, er); end
        do_txn(1, CMD_READ, 32'h0000_0030, 32'h0, lat, rd, er, tail);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL oor_rd_err got=%b exp=1", er); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oor_rd_data got=%h exp=0", rd); end
        for (int w = 0; w < 12; w++) begin
            exp_w = (w == 11) ? 32'hA5A5_A5A5 : 32'h0;
            do_txn(1, CMD_READ, 32'(w * 4), 32'h0, lat, rd, er, tail);
            checks++; if (rd !== exp_w || er !== 1'b0) begin errors++; $display("FAIL oor_word%0d got=%h err=%b exp=%h err=0", w, rd, er, exp_w); end
        end
    endtask

    task automatic test_wait_sweep();
        int lat; logic [31:0] rd; logic er; logic tail;
        int exp_lat [3];
        exp_lat = '{1, 4, 16};
        for (int i = 0; i < 3; i++) begin
            do_txn(i + 2, CMD_READ, 32'h0000_0008, 32'h0, lat, rd, er, tail);
            checks++; if (lat !== exp_lat[i]) begin errors++; $display("FAIL wait_latency inst=%0d got=%0d exp=%0d", i + 2, lat, exp_lat[i]); end
            checks++; if (tail !== 1'b0) begin errors++; $display("FAIL wait_ack_width inst=%0d got=%b exp=0", i + 2, tail); end
        end
    endtask

    task automatic test_back_to_back();
        int t1; int t2; logic [31:0] rd2;
        t1 = -1; t2 = -1; rd2 = '0;
        @(negedge clk);
        sel = 0; cmd = CMD_READ; addr = 32'h0000_0008; req = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (ack_v[0]) begin
                if (t1 < 0) begin
                    t1 = n;
                end else begin
                    t2 = n; rd2 = rdata_v[0];
                    break;
                end
            end
        end
        req = 1'b0;
        checks++; if (t1 !== 2) begin errors++; $display("FAIL b2b_first got=%0d exp=2", t1); end
        checks++; if (t2 - t1 !== 3) begin errors++; $display("FAIL b2b_gap got=%0d exp=3", t2 - t1); end
        checks++; if (rd2 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b2b_data got=%h exp=deadbeef", rd2); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int n_ack; int lat; logic [31:0] rd; logic er; logic tail;
        n_ack = 0;
        @(negedge clk);
        sel = 3; cmd = CMD_WRITE; addr = 32'h0000_0008; wdata = 32'h0000_1234; req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1; req = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (ack_v[3]) n_ack++;
        end
        checks++; if (n_ack !== 0) begin errors++; $display("FAIL rstmid_ack got=%0d exp=0", n_ack); end
        reset = 1'b0;
        do_txn(3, CMD_READ, 32'h0000_0008, 32'h0, lat, rd, er, tail);
        checks++; if (lat !== 4) begin errors++; $display("FAIL rstmid_rd_latency got=%0d exp=4", lat); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rstmid_rd_data got=%h exp=0", rd); end
        do_txn(3, CMD_WRITE, 32'h0000_0008, 32'h0000_1234, lat, rd, er, tail);
        checks++; if (lat !== 4 || er !== 1'b0) begin errors++; $display("FAIL rstmid_wr lat=%0d err=%b exp lat=4 err=0", lat, er); end
        do_txn(3, CMD_READ, 32'h0000_0008, 32'h0, lat, rd, er, tail);
        checks++; if (rd !== 32'h0000_1234) begin errors++; $display("FAIL rstmid_readback got=%h exp=00001234", rd); end
    endtask

    // Test sequence.
    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; req = 1'b0; sel = 0; cmd = 1'b0; addr = '0; wdata = '0;
        test_reset();
        test_write_read();
        test_decode_miss();
        test_out_of_range();
        test_wait_sweep();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
